// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO register-file write port.
// Build option: define MULDIV_FAST_MUL_EN to run multiplies through a one-cycle array multiply.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for start; accepts when cancel is low
// ITER  | one multiplier/quotient bit per cycle, cnt 0..31
// FIX   | sign correction, result registered into wd_*
// WB    | HI/LO write cycle (done/we_* unless cancelled)
module muldiv_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        we_hi,
  output logic        we_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] wd_lo
);

`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_WB} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opd;
  logic        is_div, neg_a, neg_b, div_zero;

  logic        accept, fast_path, sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, rem_sh, rem_diff;
  logic [63:0] mul_step, div_step, prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, res_hi, res_lo;

  assign accept    = (state == S_IDLE) && start && !cancel;
  assign fast_path = FAST_MUL && !op[1];
  assign sgn_a     = !op[0] && src_a[31];
  assign sgn_b     = !op[0] && src_b[31];
  assign abs_a     = sgn_a ? -src_a : src_a;
  assign abs_b     = sgn_b ? -src_b : src_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = fast_path ? S_FIX : S_ITER;
      S_ITER: begin
        if (cancel)                 state_nxt = S_IDLE;
        else if (cnt == LAST_ITER)  state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = cancel ? S_IDLE : S_WB;
      S_WB: begin
        done      = !cancel;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    we_hi = done;
    we_lo = done;
  end

  // Multiply: acc = {partial, multiplier}, add-then-shift-right.
  // Divide:   acc = {remainder, dividend/quotient}, shift-left-then-trial-subtract.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    mul_step = {mul_sum, acc[31:1]};
    rem_sh   = acc[63:31];
    rem_diff = rem_sh - {1'b0, opd};
    div_step = rem_diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                            : {rem_diff[31:0], acc[30:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      opd      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      is_div   <= op[1];
      neg_a    <= sgn_a;
      neg_b    <= sgn_b;
      div_zero <= op[1] && (src_b == 32'd0);
      cnt      <= '0;
      opd      <= op[1] ? abs_b : abs_a;
      acc      <= {32'd0, op[1] ? abs_a : abs_b};
    end else if (state == S_ITER) begin
      cnt <= cnt + 5'd1;
      acc <= is_div ? div_step : mul_step;
    end
  end

  // With a zero divisor the remainder ends up as |dividend|, so the normal
  // remainder sign rule hands back the raw dividend; only the quotient is pinned.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {32'd0, opd} * {32'd0, acc[31:0]};
`else
    prod = acc;
`endif
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    quo_fix  = div_zero ? 32'hFFFF_FFFF
                        : ((neg_a ^ neg_b) ? -acc[31:0] : acc[31:0]);
    rem_fix  = neg_a ? -acc[63:32] : acc[63:32];
    res_hi   = is_div ? rem_fix : prod_fix[63:32];
    res_lo   = is_div ? quo_fix : prod_fix[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_hi <= '0;
      wd_lo <= '0;
    end else if (state == S_FIX && !cancel) begin
      wd_hi <= res_hi;
      wd_lo <= res_lo;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative multiply/divide unit of the MIPS core.
- Executes MULT, MULTU, DIV and DIVU issued from the execute stage.
- Drives the write side of the HI/LO register file (`we_hi`, `we_lo`, `wd_hi`, `wd_lo`).
- Holds `busy` so issue logic stalls any later HI/LO consumer until the result is written.

## Interface
Parameters:
- `DIV_ITER`, 32, number of restoring-division iteration cycles; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  issue request; accepted only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a`  in  32  multiplicand / dividend; sampled with `start`.
- `src_b`  in  32  multiplier / divisor; sampled with `start`.
- `cancel`  in  1  pipeline flush; aborts the in-flight operation.
- `busy`  out  1  operation in flight, from the cycle after accept through the WB cycle.
- `done`  out  1  one-cycle pulse in the WB cycle.
- `we_hi`, `we_lo`  out  1  HI/LO write enables; high only in the WB cycle.
- `wd_hi`, `wd_lo`  out  32  result registers; hold the last result.

## Operation
- States:
  - IDLE: accepts `start` when `cancel`=0.
  - ITER: 32 cycles, 5-bit counter 0..31.
  - FIX: sign correction.
  - WB: single write cycle.
- Transitions: IDLE→ITER→FIX→WB→IDLE.
- Accept: latch |src_a|, |src_b|, and the sign flags (signed ops only). Unsigned ops use raw operands.
- Multiply: shift-add over the 64-bit accumulator, one multiplier bit per ITER cycle. Result {hi,lo} = 64-bit product, negated in FIX when the operand signs differ (signed op).
- Divide: radix-2 restoring over a 64-bit remainder/quotient pair, one quotient bit per ITER cycle. Results: lo = quotient, hi = remainder.
- Divide sign rules: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: detected at accept but full latency is kept. Result: hi = src_a, lo = 32'hFFFF_FFFF, no sign fixup.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0. This falls out naturally, no special case.
- `start` while `busy`: ignored, no queueing. Issue logic is required to stall.
- `cancel` in ITER or FIX: return to IDLE next cycle; no write; `wd_*` keep the previous result.
- `cancel` in WB: `we_hi`/`we_lo` and `done` are forced low combinationally; write suppressed.
- `cancel` with `start` in IDLE: start ignored.

## Timing
- Accept at edge T.
- `busy`: high T+1..T+34.
- ITER: T+1..T+32.
- FIX: T+33.
- WB: T+34. `we_hi`=`we_lo`=`done`=1 and `wd_*` valid during this cycle; HI/LO captures at the end of T+34.
- Next `start` is accepted at T+35 at the earliest.
- Reset values: `busy`=0, `done`=0, `we_hi`=0, `we_lo`=0, `wd_hi`=0, `wd_lo`=0, state IDLE, counter 0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous), no write occurs, and the unit is idle on the first edge after release.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MULT/MULTU bypass ITER and use a registered 32x32 array multiply.
  - Sequence: accept T, compute+sign-fix T+1, WB T+2.
  - `busy` high T+1..T+2.
  - Cancel rules are unchanged.
- Undefined: multiply uses the iterative path with the 34-cycle latency above.
- Division timing is identical in both builds.

## Test plan
- MULT src_a=0xFFFF_FFFD (-3), src_b=5 -> at WB: wd_hi=0xFFFF_FFFF, wd_lo=0xFFFF_FFF1. WB is at T+34, or T+2 with `MULDIV_FAST_MUL_EN`.
- MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> wd_hi=0xFFFF_FFFE, wd_lo=0x0000_0001. `done` is a one-cycle pulse.
- DIVU 100/7 -> lo=0x0000_000E, hi=0x0000_0002 at T+34. DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIV 0x1234/0 -> hi=0x0000_1234, lo=0xFFFF_FFFF at T+34. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU issued, `cancel` pulsed at T+10 -> no `we_*`/`done`, `busy`=0 at T+11, `wd_*` unchanged. A new start at T+11 is accepted. `cancel` during WB -> `we_*` stay 0.
- `rst`=0 asserted at T+20 of a DIV -> `busy`/`we_*`/`wd_*` go 0 immediately. `start` while `busy` during a later op has no effect on the result.
